// File: rtl/pc_branch_unit.sv
// Program-counter / branch-resolution stage behind the ALU: flag latch, next-PC select, start/halt FSM, retire counter.
// Latency: all outputs registered; a kCMP's flags are visible to the branch in the very next cycle.
// Backpressure: none; one instruction retires per RUN cycle, and halt_req freezes the stage until start.
//
// Ports:
//   clk, reset        - clock and synchronous active-high reset
//   start             - begin execution at START_ADDR (honoured in IDLE and HALT only)
//   op                - opcode at the current pc
//   cmp_z, cmp_lt     - ALU compare results, captured only on kCMP
//   target            - absolute branch target
//   halt_req          - terminating instruction marker
//   pc                - fetch address
//   flag_z, flag_lt   - registered compare flags
//   running, done     - RUN / HALT state decodes
//   instr_count       - saturating retired-instruction count since last start
module pc_branch_unit #(
  parameter int PC_W       = 10,
  parameter int START_ADDR = 0,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [4:0]       op,
  input  logic             cmp_z,
  input  logic             cmp_lt,
  input  logic [PC_W-1:0]  target,
  input  logic             halt_req,
  output logic [PC_W-1:0]  pc,
  output logic             flag_z,
  output logic             flag_lt,
  output logic             running,
  output logic             done,
  output logic [CNT_W-1:0] instr_count
);

  // Opcode encodings shared with the decoder.
  localparam logic [4:0] K_NOP = 5'd0;
  localparam logic [4:0] K_ADD = 5'd1;
  localparam logic [4:0] K_SUB = 5'd2;
  localparam logic [4:0] K_CMP = 5'd5;
  localparam logic [4:0] K_BE  = 5'd8;
  localparam logic [4:0] K_BL  = 5'd9;
  localparam logic [4:0] K_BG  = 5'd10;
  localparam logic [4:0] K_BA  = 5'd11;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);

  logic [1:0]       r_state;
  logic [PC_W-1:0]  r_pc;
  logic             r_flag_z;
  logic             r_flag_lt;
  logic [CNT_W-1:0] r_count;

  logic             w_take;
  logic [PC_W-1:0]  w_pc_inc;
  logic [PC_W-1:0]  w_pc_next;
  logic             w_cnt_sat;

  // Branch decision uses only the registered flags; live cmp_* are for kCMP capture.
  always_comb begin
    w_take = 1'b0;
    case (op)
      K_BA:    w_take = 1'b1;
      K_BE:    w_take = r_flag_z;
      K_BL:    w_take = r_flag_lt;
      K_BG:    w_take = ~r_flag_z & ~r_flag_lt;
      default: w_take = 1'b0;
    endcase
  end

  // Natural overflow of the PC_W-bit add gives the modulo-2^PC_W wrap.
  assign w_pc_inc  = r_pc + {{(PC_W-1){1'b0}}, 1'b1};
  assign w_pc_next = w_take ? target : w_pc_inc;
  assign w_cnt_sat = &r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_pc      <= START_PC;
      r_flag_z  <= 1'b0;
      r_flag_lt <= 1'b0;
      r_count   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_pc <= START_PC;
          if (start) begin
            r_state   <= S_RUN;
            r_flag_z  <= 1'b0;
            r_flag_lt <= 1'b0;
            r_count   <= '0;
          end
        end
        S_RUN: begin
          // The halting instruction still retires, so it is counted.
          if (!w_cnt_sat) r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
          if (halt_req) begin
            // pc and flags held: halt outranks both branch and flag capture.
            r_state <= S_HALT;
          end else begin
            r_pc <= w_pc_next;
            if (op == K_CMP) begin
              r_flag_z  <= cmp_z;
              r_flag_lt <= cmp_lt;
            end
          end
        end
        S_HALT: begin
          if (start) begin
            r_state   <= S_RUN;
            r_pc      <= START_PC;
            r_flag_z  <= 1'b0;
            r_flag_lt <= 1'b0;
            r_count   <= '0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_pc    <= START_PC;
        end
      endcase
    end
  end

  assign pc          = r_pc;
  assign flag_z      = r_flag_z;
  assign flag_lt     = r_flag_lt;
  assign running     = (r_state == S_RUN);
  assign done        = (r_state == S_HALT);
  assign instr_count = r_count;

endmodule

// File: tb/tb_pc_branch_unit.sv
// Self-checking bench for pc_branch_unit: vector table on the default-sized unit, hand sequence on a narrow one.
// Latency: expectations are the outputs one rising edge after the inputs are applied.
// Backpressure: not applicable.
module tb_pc_branch_unit;

  localparam logic [4:0] OP_ADD = 5'd1;
  localparam logic [4:0] OP_CMP = 5'd5;
  localparam logic [4:0] OP_BE  = 5'd8;
  localparam logic [4:0] OP_BL  = 5'd9;
  localparam logic [4:0] OP_BG  = 5'd10;
  localparam logic [4:0] OP_BA  = 5'd11;
  localparam logic [4:0] OP_UND = 5'd31;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default-sized unit.
  logic        reset, start, cmp_z, cmp_lt, halt_req;
  logic [4:0]  op;
  logic [9:0]  target;
  logic [9:0]  pc;
  logic        flag_z, flag_lt, running, done;
  logic [15:0] instr_count;

  pc_branch_unit dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .cmp_z(cmp_z), .cmp_lt(cmp_lt),
    .target(target), .halt_req(halt_req), .pc(pc), .flag_z(flag_z), .flag_lt(flag_lt),
    .running(running), .done(done), .instr_count(instr_count)
  );

  // Narrow unit for wrap and saturation.
  logic        s_reset, s_start;
  logic [4:0]  s_op;
  logic [3:0]  s_target;
  logic [3:0]  s_pc;
  logic        s_flag_z, s_flag_lt, s_running, s_done;
  logic [2:0]  s_count;

  pc_branch_unit #(.PC_W(4), .START_ADDR(14), .CNT_W(3)) dut_s (
    .clk(clk), .reset(s_reset), .start(s_start), .op(s_op), .cmp_z(1'b0), .cmp_lt(1'b0),
    .target(s_target), .halt_req(1'b0), .pc(s_pc), .flag_z(s_flag_z), .flag_lt(s_flag_lt),
    .running(s_running), .done(s_done), .instr_count(s_count)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  typedef struct {
    logic       rst;
    logic       st;
    logic [4:0] op;
    logic       cz;
    logic       clt;
    logic [9:0] tgt;
    logic       hr;
    logic [9:0] e_pc;
    logic       e_fz;
    logic       e_flt;
    logic       e_run;
    logic       e_done;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic rst, input logic st, input logic [4:0] o,
                              input logic cz, input logic clt, input logic [9:0] tgt, input logic hr,
                              input logic [9:0] e_pc, input logic e_fz, input logic e_flt,
                              input logic e_run, input logic e_done, input logic [15:0] e_cnt);
    vec_t v;
    v.rst = rst; v.st = st; v.op = o; v.cz = cz; v.clt = clt; v.tgt = tgt; v.hr = hr;
    v.e_pc = e_pc; v.e_fz = e_fz; v.e_flt = e_flt; v.e_run = e_run; v.e_done = e_done; v.e_cnt = e_cnt;
    vecs.push_back(v);
  endfunction

  initial begin
    // rst st op      cz clt tgt hr | pc  fz flt run done cnt
    add(1, 0, OP_ADD, 0, 0,  0, 0,    0, 0, 0, 0, 0,  0);  // reset
    add(0, 1, OP_ADD, 0, 0,  0, 0,    0, 0, 0, 1, 0,  0);  // start: first RUN cycle at 0
    add(0, 0, OP_ADD, 0, 0,  0, 0,    1, 0, 0, 1, 0,  1);
    add(0, 0, OP_ADD, 0, 0,  0, 0,    2, 0, 0, 1, 0,  2);
    add(0, 0, OP_ADD, 0, 0,  0, 0,    3, 0, 0, 1, 0,  3);
    add(0, 0, OP_ADD, 0, 0,  0, 0,    4, 0, 0, 1, 0,  4);
    add(0, 1, OP_ADD, 0, 0,  0, 0,    5, 0, 0, 1, 0,  5);  // start ignored in RUN
    add(0, 0, OP_CMP, 1, 0,  0, 0,    6, 1, 0, 1, 0,  6);  // capture z
    add(0, 0, OP_BE,  0, 0, 40, 0,   40, 1, 0, 1, 0,  7);  // BE taken on new flag
    add(0, 0, OP_BL,  0, 1,  7, 0,   41, 1, 0, 1, 0,  8);  // BL not taken
    add(0, 0, OP_CMP, 0, 0,  0, 0,   42, 0, 0, 1, 0,  9);
    add(0, 0, OP_BE,  1, 0,  9, 0,   43, 0, 0, 1, 0, 10);  // live cmp_z ignored
    add(0, 0, OP_CMP, 0, 1,  0, 0,   44, 0, 1, 1, 0, 11);
    add(0, 0, OP_BG,  0, 0,  9, 0,   45, 0, 1, 1, 0, 12);  // BG not taken with lt
    add(0, 0, OP_CMP, 0, 0,  0, 0,   46, 0, 0, 1, 0, 13);
    add(0, 0, OP_BG,  1, 1,  9, 0,    9, 0, 0, 1, 0, 14);  // BG taken
    add(0, 0, OP_CMP, 1, 0,  0, 0,   10, 1, 0, 1, 0, 15);
    add(0, 0, OP_BA,  0, 0, 20, 1,   10, 1, 0, 0, 1, 16);  // halt beats BA
    add(0, 0, OP_CMP, 0, 1, 30, 1,   10, 1, 0, 0, 1, 16);  // HALT frozen
    add(0, 1, OP_ADD, 0, 0,  0, 0,    0, 0, 0, 1, 0,  0);  // restart clears
    add(0, 0, OP_CMP, 1, 0,  0, 0,    1, 1, 0, 1, 0,  1);
    add(0, 0, OP_ADD, 0, 0,  0, 0,    2, 1, 0, 1, 0,  2);
    add(1, 1, OP_BA,  0, 0, 50, 0,    0, 0, 0, 0, 0,  0);  // reset mid-run, start no effect
    add(0, 0, OP_ADD, 0, 0,  0, 0,    0, 0, 0, 0, 0,  0);  // stays IDLE
    add(0, 1, OP_ADD, 0, 0,  0, 0,    0, 0, 0, 1, 0,  0);
    add(0, 0, OP_ADD, 0, 0,  0, 0,    1, 0, 0, 1, 0,  1);
    add(0, 0, OP_UND, 0, 0,  3, 0,    2, 0, 0, 1, 0,  2);  // undefined op = pc+1
    add(0, 0, OP_CMP, 1, 1,  0, 1,    2, 0, 0, 0, 1,  3);  // halt beats flag capture

    reset = 1'b1; start = 1'b0; op = OP_ADD; cmp_z = 1'b0; cmp_lt = 1'b0; target = '0; halt_req = 1'b0;
    s_reset = 1'b1; s_start = 1'b0; s_op = OP_ADD; s_target = 4'd3;

    for (int i = 0; i < vecs.size(); i++) begin
      reset = vecs[i].rst; start = vecs[i].st; op = vecs[i].op;
      cmp_z = vecs[i].cz; cmp_lt = vecs[i].clt; target = vecs[i].tgt; halt_req = vecs[i].hr;
      @(posedge clk); #1;
      check("pc",      i, 16'(pc),      16'(vecs[i].e_pc));
      check("flag_z",  i, 16'(flag_z),  16'(vecs[i].e_fz));
      check("flag_lt", i, 16'(flag_lt), 16'(vecs[i].e_flt));
      check("running", i, 16'(running), 16'(vecs[i].e_run));
      check("done",    i, 16'(done),    16'(vecs[i].e_done));
      check("count",   i, instr_count,  vecs[i].e_cnt);
    end

    // Narrow unit: reset was held across the table, so it is in IDLE at 14.
    s_reset = 1'b0;
    @(posedge clk); #1;
    check("s_idle_pc", 0, 16'(s_pc), 16'd14);
    check("s_idle_run", 0, 16'(s_running), 16'd0);
    s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    check("s_start_pc", 0, 16'(s_pc), 16'd14);
    check("s_start_cnt", 0, 16'(s_count), 16'd0);
    for (int k = 1; k <= 10; k++) begin
      // Non-branch ops (including BA would not be) keep pc+1; use ADD.
      s_op = OP_ADD;
      @(posedge clk); #1;
      check("s_wrap_pc", k, 16'(s_pc), 16'((14 + k) % 16));
      check("s_sat_cnt", k, 16'(s_count), 16'((k > 7) ? 7 : k));
    end
    check("s_flags", 0, 16'({s_flag_z, s_flag_lt}), 16'd0);
    check("s_done", 0, 16'(s_done), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_branch_unit.md
Name: pc_branch_unit

Overview:
- Program-counter and branch-resolution stage that sits directly downstream of the ALU.
- Latches the ALU compare outputs (z, lt) into a flag register when a kCMP executes.
- Resolves kBE/kBL/kBG/kBA using those registered flags and produces the next instruction-fetch address.
- Also runs the start/halt control state machine and a saturating executed-instruction counter.

Parameters:
- PC_W, 10, width of the program counter (instruction memory depth 2^PC_W).
- START_ADDR, 0, PC value loaded on reset and on every start.
- CNT_W, 16, width of the executed-instruction counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begin program execution from START_ADDR (level-sampled, acted on only in IDLE/HALT).
- op  input  5  opcode of the instruction currently at pc (definitions package k* constants).
- cmp_z  input  1  ALU z output (in_a == in_b), valid when op == kCMP.
- cmp_lt  input  1  ALU lt output (in_a < in_b, unsigned), valid when op == kCMP.
- target  input  PC_W  absolute branch target for the current instruction.
- halt_req  input  1  decoder asserts on the program's terminating instruction.
- pc  output  PC_W  current fetch address (registered).
- flag_z  output  1  registered equal flag.
- flag_lt  output  1  registered less-than flag.
- running  output  1  high while in RUN.
- done  output  1  high while in HALT.
- instr_count  output  CNT_W  instructions retired since last start, saturating.

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- Reset overrides all other inputs in the same edge, including mid-RUN.
  - State goes to IDLE; pc = START_ADDR; flag_z = 0; flag_lt = 0; running = 0; done = 0; instr_count = 0.
- States: IDLE, RUN, HALT. running = (state == RUN) and done = (state == HALT); both are registered state decodes.
- IDLE:
  - pc held at START_ADDR.
  - start = 1 → RUN on the next edge; pc stays START_ADDR, so the first RUN cycle executes START_ADDR.
- RUN: one instruction retires per cycle, at the pc currently presented.
  - halt_req = 1 → HALT. pc is held (not advanced, no branch taken). This instruction counts as retired. halt_req has priority over branch and over flag update.
  - Otherwise pc_next is selected as follows:
    - kBA → target.
    - kBE → target if flag_z, else pc+1.
    - kBL → target if flag_lt, else pc+1.
    - kBG → target if (!flag_z && !flag_lt), else pc+1.
    - All other opcodes → pc+1.
  - pc+1 wraps modulo 2^PC_W: all-ones → 0.
  - Branches evaluate the registered flags, never the live cmp_z/cmp_lt.
  - op == kCMP (and no halt_req) → flag_z <= cmp_z and flag_lt <= cmp_lt at the edge. A branch in the immediately following cycle sees the new flags.
  - Flags are unchanged by every other opcode.
  - start is ignored in RUN.
  - instr_count increments by 1 per RUN cycle and saturates at all-ones (no wrap).
- HALT:
  - pc, flags and instr_count are frozen; op, cmp_* and halt_req are ignored.
  - start = 1 → RUN on the next edge with pc = START_ADDR, flags = 0, instr_count = 0; done drops the same edge.
- Undefined opcode values behave as non-branch (pc+1).

Test Plan:
- Reset then start: reset 1 cycle, start = 1 for 1 cycle, op = kADD for 5 cycles → running = 1, pc sequence 0,0,1,2,3,4; instr_count = 5; flags stay 0.
- CMP then branch: at pc = 3 apply op = kCMP, cmp_z = 1, cmp_lt = 0; next cycle op = kBE, target = 40 → flag_z = 1 after the CMP edge, pc = 40. Repeat with kBL, target = 7 → not taken, pc = 41.
- Branch ignores live compare inputs: flags = 0, op = kBE, cmp_z = 1, target = 9 → pc = pc+1, flag_z stays 0. Then flag_lt = 1, op = kBG → not taken. Then flags = 0, op = kBG → taken.
- Wrap and saturation: PC_W = 4, run from START_ADDR = 14 with non-branch ops → pc 14,15,0,1. CNT_W = 3, run 10 instructions → instr_count holds at 7.
- Halt priority and restart: op = kBA, target = 20, halt_req = 1 at pc = 5 → next cycle done = 1, running = 0, pc = 5, count includes the halting instruction. start = 1 → pc = START_ADDR, flags = 0, count = 0, done = 0.
- Reset mid-run: in RUN with flag_z = 1, pc = 12, assert reset → next edge IDLE, pc = START_ADDR, all flags, count and status outputs 0; start asserted in the same cycle as reset has no effect.
